spm_boot_loader: RTL and testbench
==================================

Name: spm_boot_loader

Overview:
Parametrised boot and debug controller for the RISC_SPM system. It owns the SRAM port from reset until a program image has been streamed in from a host, holding the processor in reset meanwhile. It then releases the processor and hands the SRAM over to it. When the processor halts, it takes the SRAM back for probe reads and optional reboot, replacing backdoor memory loading and probing with a synthesizable path.

Parameters:
word_size, 8, SRAM data width and host data width
addr_size, 8, SRAM address width; DEPTH = 2**addr_size
clear_on_boot, 1, 1 = zero-fill all DEPTH words before LOAD; 0 = skip CLEAR
read_lat, 1, SRAM read latency in cycles (1..3)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
host_valid  in  1  host record valid
host_ready  out  1  loader accepts record
host_addr  in  addr_size  target SRAM address
host_data  in  word_size  word to write
host_last  in  1  final record of image
mem_sel  out  1  1 = loader drives SRAM, 0 = processor drives SRAM
mem_addr  out  addr_size  loader SRAM address
mem_wdata  out  word_size  loader SRAM write data
mem_write  out  1  loader write strobe, one word per cycle
mem_read  out  1  loader read strobe
mem_rdata  in  word_size  SRAM read data, valid read_lat cycles after mem_read
cpu_rst_n  out  1  processor reset, active-low
cpu_halt  in  1  processor has executed HALT
reboot  in  1  restart boot sequence (honoured only in HALTED)
probe_req  in  1  read request (honoured only in HALTED)
probe_addr  in  addr_size  probe address
probe_data  out  word_size  probe result
probe_valid  out  1  probe_data valid, one-cycle pulse
boot_done  out  1  high in RUN and HALTED
load_count  out  addr_size+1  records accepted in the current LOAD, saturating at all-ones

Behaviour:
- All outputs are registered.
- Reset values:
  - State = CLEAR if clear_on_boot, else LOAD.
  - mem_sel=1, cpu_rst_n=0.
  - host_ready=0, mem_write=0, mem_read=0.
  - mem_addr=0, mem_wdata=0.
  - probe_valid=0, probe_data=0.
  - boot_done=0, load_count=0.
- Reset asserted in any state, including mid-CLEAR, mid-LOAD or mid-probe, aborts the operation. The next state is the reset state; in-flight probes are dropped.
- CLEAR:
  - mem_write=1 and mem_wdata=0 for exactly DEPTH consecutive cycles, mem_addr = 0,1,...,DEPTH-1.
  - host_ready=0.
  - Moves to LOAD after the write to DEPTH-1; the address counter does not wrap into a second pass.
- LOAD:
  - host_ready=1 from the first LOAD cycle.
  - A handshake (host_valid & host_ready) at edge N drives mem_write=1, mem_addr=host_addr, mem_wdata=host_data during cycle N+1.
  - load_count increments at that handshake.
  - Back-to-back handshakes are accepted every cycle.
  - A handshake with host_last=1 drops host_ready the next cycle and moves to START.
  - host_last without host_valid is ignored.
  - Duplicate addresses are allowed; the last write wins.
- START (1 cycle): final host write completes; mem_sel=0; cpu_rst_n stays 0.
- RUN:
  - cpu_rst_n=1, mem_sel=0, boot_done=1.
  - mem_write and mem_read are held 0.
  - probe_req and reboot are ignored.
  - cpu_halt=1 moves to HALTED.
- HALTED:
  - mem_sel=1; cpu_rst_n stays 1, so the processor remains halted and its registers are preserved.
  - probe_req: mem_read=1 and mem_addr=probe_addr for 1 cycle.
  - read_lat cycles later, mem_rdata is captured; probe_data is updated and probe_valid pulses the following cycle.
  - One probe may be outstanding; probe_req while busy is ignored.
  - reboot: next cycle cpu_rst_n=0, boot_done=0, load_count=0, state = CLEAR or LOAD per clear_on_boot. A pending probe is dropped.
  - reboot and probe_req in the same cycle: reboot wins.
- cpu_halt outside RUN is ignored.
- load_count width is addr_size+1, so DEPTH records fit without overflow. It saturates and never wraps.

Test Plan:
1. Default params, rst high 2 cycles then low -> mem_write high 256 consecutive cycles, mem_addr 0..255, mem_wdata 0; host_ready rises the cycle after addr 255.
2. LOAD records (0,0x00),(1,0x52),(2,130),(130,2),(139,0xF0 last) back-to-back -> 5 writes with matching addr/data one cycle after each handshake; load_count=5; mem_sel=0 one cycle after the last write; cpu_rst_n=1 one cycle later.
3. host_valid held high during CLEAR with addr 5, data 0x77 -> no host write until LOAD; record accepted on the first LOAD cycle; CLEAR sequence unaltered.
4. RUN, then cpu_halt=1 -> mem_sel=1; probe_req addr 128 with SRAM returning 6, read_lat=1 -> mem_read 1 cycle; probe_valid=1 with probe_data=6 two cycles after the mem_read cycle.
5. HALTED, reboot=1 together with probe_req -> no probe_valid; cpu_rst_n=0, boot_done=0, load_count=0 next cycle; CLEAR restarts at addr 0.
6. clear_on_boot=0, rst asserted after 2 LOAD handshakes -> all outputs at reset values; load_count=0; host_ready=1 again the cycle after rst deasserts.

Source files
------------

// File: rtl/spm_boot_loader.sv
// rtl/spm_boot_loader.sv - boot and debug controller owning the RISC_SPM SRAM port
module spm_boot_loader #(
    parameter int word_size     = 8,
    parameter int addr_size     = 8,
    parameter int clear_on_boot = 1,
    parameter int read_lat      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 host_valid,
    output logic                 host_ready,
    input  logic [addr_size-1:0] host_addr,
    input  logic [word_size-1:0] host_data,
    input  logic                 host_last,
    output logic                 mem_sel,
    output logic [addr_size-1:0] mem_addr,
    output logic [word_size-1:0] mem_wdata,
    output logic                 mem_write,
    output logic                 mem_read,
    input  logic [word_size-1:0] mem_rdata,
    output logic                 cpu_rst_n,
    input  logic                 cpu_halt,
    input  logic                 reboot,
    input  logic                 probe_req,
    input  logic [addr_size-1:0] probe_addr,
    output logic [word_size-1:0] probe_data,
    output logic                 probe_valid,
    output logic                 boot_done,
    output logic [addr_size:0]   load_count
);

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_RUN    = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // Entry state after reset or reboot: zero-fill first only when requested.
    localparam state_t         BOOT_STATE = (clear_on_boot != 0) ? ST_CLEAR : ST_LOAD;
    localparam logic [addr_size:0]   CNT_MAX   = '1;
    localparam logic [addr_size-1:0] LAST_ADDR = '1;
    localparam logic [1:0]           LAT_INIT  = 2'(read_lat);

    state_t                 state_q, state_d;
    logic [addr_size-1:0]   clr_cnt_q, clr_cnt_d;
    logic                   busy_q, busy_d;
    logic [1:0]             lat_cnt_q, lat_cnt_d;

    logic                   host_ready_q, host_ready_d;
    logic                   mem_sel_q, mem_sel_d;
    logic [addr_size-1:0]   mem_addr_q, mem_addr_d;
    logic [word_size-1:0]   mem_wdata_q, mem_wdata_d;
    logic                   mem_write_q, mem_write_d;
    logic                   mem_read_q, mem_read_d;
    logic                   cpu_rst_n_q, cpu_rst_n_d;
    logic [word_size-1:0]   probe_data_q, probe_data_d;
    logic                   probe_valid_q, probe_valid_d;
    logic                   boot_done_q, boot_done_d;
    logic [addr_size:0]     load_count_q, load_count_d;

    // State register and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT_STATE;
            clr_cnt_q     <= '0;
            busy_q        <= 1'b0;
            lat_cnt_q     <= '0;
            host_ready_q  <= 1'b0;
            mem_sel_q     <= 1'b1;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            cpu_rst_n_q   <= 1'b0;
            probe_data_q  <= '0;
            probe_valid_q <= 1'b0;
            boot_done_q   <= 1'b0;
            load_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            busy_q        <= busy_d;
            lat_cnt_q     <= lat_cnt_d;
            host_ready_q  <= host_ready_d;
            mem_sel_q     <= mem_sel_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_write_q   <= mem_write_d;
            mem_read_q    <= mem_read_d;
            cpu_rst_n_q   <= cpu_rst_n_d;
            probe_data_q  <= probe_data_d;
            probe_valid_q <= probe_valid_d;
            boot_done_q   <= boot_done_d;
            load_count_q  <= load_count_d;
        end
    end

    // Next-state and next-output logic; strobes default low, data/address hold.
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        busy_d        = busy_q;
        lat_cnt_d     = lat_cnt_q;
        host_ready_d  = 1'b0;
        mem_sel_d     = mem_sel_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_write_d   = 1'b0;
        mem_read_d    = 1'b0;
        cpu_rst_n_d   = cpu_rst_n_q;
        probe_data_d  = probe_data_q;
        probe_valid_d = 1'b0;
        boot_done_d   = boot_done_q;
        load_count_d  = load_count_q;

        case (state_q)
            ST_CLEAR: begin
                // One zero write per cycle over the whole array, single pass.
                mem_sel_d   = 1'b1;
                cpu_rst_n_d = 1'b0;
                boot_done_d = 1'b0;
                mem_write_d = 1'b1;
                mem_addr_d  = clr_cnt_q;
                mem_wdata_d = '0;
                clr_cnt_d   = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    clr_cnt_d = '0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mem_sel_d    = 1'b1;
                cpu_rst_n_d  = 1'b0;
                host_ready_d = 1'b1;
                if (host_valid && host_ready_q) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = host_addr;
                    mem_wdata_d = host_data;
                    if (load_count_q != CNT_MAX) begin
                        load_count_d = load_count_q + 1'b1;
                    end
                    if (host_last) begin
                        host_ready_d = 1'b0;
                        state_d      = ST_START;
                    end
                end
            end
            ST_START: begin
                // Final host write is on the bus this cycle; hand SRAM to the CPU next.
                mem_sel_d = 1'b0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                mem_sel_d   = 1'b0;
                cpu_rst_n_d = 1'b1;
                boot_done_d = 1'b1;
                if (cpu_halt) begin
                    mem_sel_d = 1'b1;
                    state_d   = ST_HALTED;
                end
            end
            ST_HALTED: begin
                mem_sel_d   = 1'b1;
                cpu_rst_n_d = 1'b1;
                boot_done_d = 1'b1;
                if (reboot) begin
                    // Reboot beats any probe and drops one already in flight.
                    state_d      = BOOT_STATE;
                    cpu_rst_n_d  = 1'b0;
                    boot_done_d  = 1'b0;
                    load_count_d = '0;
                    clr_cnt_d    = '0;
                    busy_d       = 1'b0;
                    lat_cnt_d    = '0;
                end else if (busy_q) begin
                    if (lat_cnt_q == 2'd0) begin
                        busy_d        = 1'b0;
                        probe_valid_d = 1'b1;
                        probe_data_d  = mem_rdata;
                    end else begin
                        lat_cnt_d = lat_cnt_q - 1'b1;
                    end
                end else if (probe_req) begin
                    mem_read_d = 1'b1;
                    mem_addr_d = probe_addr;
                    busy_d     = 1'b1;
                    lat_cnt_d  = LAT_INIT;
                end
            end
            default: begin
                state_d = BOOT_STATE;
            end
        endcase
    end

    assign host_ready  = host_ready_q;
    assign mem_sel     = mem_sel_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_write   = mem_write_q;
    assign mem_read    = mem_read_q;
    assign cpu_rst_n   = cpu_rst_n_q;
    assign probe_data  = probe_data_q;
    assign probe_valid = probe_valid_q;
    assign boot_done   = boot_done_q;
    assign load_count  = load_count_q;

endmodule

// File: tb/tb_spm_boot_loader.sv
// tb/tb_spm_boot_loader.sv - scoreboard bench for spm_boot_loader
module tb_spm_boot_loader;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } pr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Main instance: default parameters
    logic       rst, host_valid, host_last, cpu_halt, reboot, probe_req;
    logic [7:0] host_addr, host_data, probe_addr, mem_rdata;
    logic       host_ready, mem_sel, mem_write, mem_read, cpu_rst_n, probe_valid, boot_done;
    logic [7:0] mem_addr, mem_wdata, probe_data;
    logic [8:0] load_count;

    // Second instance: no clear, read_lat=2
    logic       rst_b, host_valid_b, host_last_b;
    logic [7:0] host_addr_b, host_data_b, mem_rdata_b;
    logic       host_ready_b, mem_sel_b, mem_write_b, mem_read_b, cpu_rst_n_b, probe_valid_b, boot_done_b;
    logic [7:0] mem_addr_b, mem_wdata_b, probe_data_b;
    logic [8:0] load_count_b;

    spm_boot_loader dut (
        .clk(clk), .rst(rst), .host_valid(host_valid), .host_ready(host_ready),
        .host_addr(host_addr), .host_data(host_data), .host_last(host_last),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata),
        .cpu_rst_n(cpu_rst_n), .cpu_halt(cpu_halt), .reboot(reboot),
        .probe_req(probe_req), .probe_addr(probe_addr), .probe_data(probe_data),
        .probe_valid(probe_valid), .boot_done(boot_done), .load_count(load_count)
    );

    spm_boot_loader #(.clear_on_boot(0), .read_lat(2)) dut_b (
        .clk(clk), .rst(rst_b), .host_valid(host_valid_b), .host_ready(host_ready_b),
        .host_addr(host_addr_b), .host_data(host_data_b), .host_last(host_last_b),
        .mem_sel(mem_sel_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_write(mem_write_b), .mem_read(mem_read_b), .mem_rdata(mem_rdata_b),
        .cpu_rst_n(cpu_rst_n_b), .cpu_halt(1'b0), .reboot(1'b0),
        .probe_req(1'b0), .probe_addr(8'h00), .probe_data(probe_data_b),
        .probe_valid(probe_valid_b), .boot_done(boot_done_b), .load_count(load_count_b)
    );

    // SRAM model for the main instance, one-cycle read latency
    logic [7:0] sram [256];
    always @(posedge clk) begin
        if (mem_sel && mem_write) sram[mem_addr] <= mem_wdata;
        if (mem_read) mem_rdata <= sram[mem_addr];
    end

    logic [7:0] ref_mem [256];
    wr_t exp_wr[$];
    pr_t exp_pr[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    task automatic check_reset_b();
        check("b_rst_host_ready", host_ready_b, 0);
        check("b_rst_mem_sel", mem_sel_b, 1);
        check("b_rst_cpu_rst_n", cpu_rst_n_b, 0);
        check("b_rst_mem_write", mem_write_b, 0);
        check("b_rst_mem_read", mem_read_b, 0);
        check("b_rst_mem_addr", mem_addr_b, 0);
        check("b_rst_mem_wdata", mem_wdata_b, 0);
        check("b_rst_probe_valid", probe_valid_b, 0);
        check("b_rst_probe_data", probe_data_b, 0);
        check("b_rst_boot_done", boot_done_b, 0);
        check("b_rst_load_count", load_count_b, 0);
    endtask

    task automatic push_clear(input int first_cyc);
        for (int i = 0; i < 256; i++) begin
            wr_t e;
            e.cyc = first_cyc + i; e.addr = 8'(i); e.data = 8'h00;
            exp_wr.push_back(e);
            ref_mem[i] = 8'h00;
        end
    endtask

    // Scoreboard monitor: every SRAM write and probe result is popped and compared
    always @(negedge clk) begin
        if (mem_write) begin
            if (exp_wr.size() == 0) begin
                check("unexp_write", mem_write, 0);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                check("wr_cyc", cyc, e.cyc);
                check("wr_addr", mem_addr, e.addr);
                check("wr_data", mem_wdata, e.data);
                check("wr_sel", mem_sel, 1);
            end
        end
        if (probe_valid) begin
            if (exp_pr.size() == 0) begin
                check("unexp_probe", probe_valid, 0);
            end else begin
                pr_t p;
                p = exp_pr.pop_front();
                check("pr_cyc", cyc, p.cyc);
                check("pr_data", probe_data, p.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] rec_a [6];
        logic [7:0] rec_d [6];
        logic [7:0] pa [6];
        int k, n, nrec;
        rec_a = '{8'd0, 8'd1, 8'd2, 8'd130, 8'd128, 8'd139};
        rec_d = '{8'h00, 8'h52, 8'd130, 8'd2, 8'd6, 8'hF0};
        pa    = '{8'd128, 8'd1, 8'd139, 8'd130, 8'd77, 8'd5};

        rst = 1; host_valid = 0; host_last = 0; host_addr = 0; host_data = 0;
        cpu_halt = 0; reboot = 0; probe_req = 0; probe_addr = 0;
        rst_b = 1; host_valid_b = 0; host_last_b = 0; host_addr_b = 0; host_data_b = 0;
        mem_rdata_b = 8'h3C;

        repeat (2) @(negedge clk);
        check("rst_mem_sel", mem_sel, 1);
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_host_ready", host_ready, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_probe_valid", probe_valid, 0);
        check("rst_probe_data", probe_data, 0);
        check("rst_boot_done", boot_done, 0);
        check("rst_load_count", load_count, 0);

        // CLEAR with a record already waiting on the host port
        rst = 0;
        k = cyc;
        push_clear(k + 1);
        host_valid = 1; host_addr = 8'd5; host_data = 8'h77; host_last = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!host_ready && n < 400);
        check("hr_rise", host_ready, 1);
        check("hr_rise_cyc", cyc, k + 257);
        begin
            wr_t e;
            e.cyc = cyc + 1; e.addr = 8'd5; e.data = 8'h77;
            exp_wr.push_back(e);
            ref_mem[5] = 8'h77;
        end
        nrec = 1;

        // Back-to-back image records
        for (int i = 0; i < 6; i++) begin
            wr_t e;
            @(negedge clk);
            check("hr_load", host_ready, 1);
            check("lc_run", load_count, nrec);
            host_addr = rec_a[i]; host_data = rec_d[i]; host_last = (i == 5);
            e.cyc = cyc + 1; e.addr = rec_a[i]; e.data = rec_d[i];
            exp_wr.push_back(e);
            ref_mem[rec_a[i]] = rec_d[i];
            nrec++;
        end
        @(negedge clk);
        host_valid = 0; host_last = 0;
        check("hr_drop", host_ready, 0);
        check("lc_final", load_count, nrec);
        check("start_sel", mem_sel, 1);
        @(negedge clk);
        check("start_sel_off", mem_sel, 0);
        check("start_cpu_rst", cpu_rst_n, 0);
        check("start_done", boot_done, 0);
        @(negedge clk);
        check("run_cpu_rst", cpu_rst_n, 1);
        check("run_done", boot_done, 1);
        check("run_sel", mem_sel, 0);

        // probe_req and reboot are ignored in RUN
        reboot = 1; probe_req = 1; probe_addr = 8'd1;
        @(negedge clk);
        reboot = 0; probe_req = 0;
        check("run_no_read", mem_read, 0);
        check("run_no_reboot", cpu_rst_n, 1);
        check("run_done_hold", boot_done, 1);
        cpu_halt = 1;
        @(negedge clk);
        check("halt_sel", mem_sel, 1);
        check("halt_cpu_rst", cpu_rst_n, 1);
        check("halt_done", boot_done, 1);

        // Probes, with a second request while busy that must be ignored
        for (int i = 0; i < 6; i++) begin
            pr_t p;
            probe_req = 1; probe_addr = pa[i];
            p.cyc = cyc + 3; p.data = ref_mem[pa[i]];
            exp_pr.push_back(p);
            @(negedge clk);
            check("probe_read", mem_read, 1);
            check("probe_addr", mem_addr, pa[i]);
            probe_addr = pa[i] ^ 8'hFF;
            @(negedge clk);
            check("probe_busy_ign", mem_read, 0);
            probe_req = 0;
            @(negedge clk);
        end
        @(negedge clk);
        check("probe_q_empty", exp_pr.size(), 0);

        // Reboot together with a probe: reboot wins, CLEAR restarts
        reboot = 1; probe_req = 1; probe_addr = 8'd128;
        k = cyc;
        push_clear(k + 2);
        @(negedge clk);
        reboot = 0; probe_req = 0;
        check("rb_cpu_rst", cpu_rst_n, 0);
        check("rb_done", boot_done, 0);
        check("rb_lc", load_count, 0);
        check("rb_read", mem_read, 0);
        check("rb_sel", mem_sel, 1);
        repeat (257) @(negedge clk);
        check("rb_hr", host_ready, 1);
        check("wr_q_empty", exp_wr.size(), 0);
        check("pr_q_empty", exp_pr.size(), 0);

        // Second instance: reset straight to LOAD, reset in mid-LOAD
        check_reset_b();
        rst_b = 0;
        @(negedge clk);
        check("b_hr_first", host_ready_b, 1);
        check("b_no_write", mem_write_b, 0);
        host_valid_b = 1; host_addr_b = 8'd10; host_data_b = 8'hA1;
        @(negedge clk);
        check("b_w1", mem_write_b, 1);
        check("b_w1_addr", mem_addr_b, 10);
        check("b_w1_data", mem_wdata_b, 8'hA1);
        check("b_lc1", load_count_b, 1);
        host_addr_b = 8'd11; host_data_b = 8'hB2;
        @(negedge clk);
        check("b_w2_addr", mem_addr_b, 11);
        check("b_w2_data", mem_wdata_b, 8'hB2);
        check("b_lc2", load_count_b, 2);
        rst_b = 1; host_addr_b = 8'd12; host_data_b = 8'hC3;
        @(negedge clk);
        check_reset_b();
        rst_b = 0;
        @(negedge clk);
        check("b_hr_again", host_ready_b, 1);
        check("b_no_write2", mem_write_b, 0);
        check("b_lc0", load_count_b, 0);
        @(negedge clk);
        host_valid_b = 0;
        check("b_w3", mem_write_b, 1);
        check("b_w3_addr", mem_addr_b, 12);
        check("b_w3_data", mem_wdata_b, 8'hC3);
        check("b_lc3", load_count_b, 1);
        check("b_sel", mem_sel_b, 1);
        check("b_cpu_rst", cpu_rst_n_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
